uart_frame_parser: RTL and testbench
====================================

// Module: uart_frame_parser
// PURPOSE
//  Consumes the byte stream from the UART receiver (byte strobe + data) and assembles command frames.
//  Frame: SOF, CMD, LEN, LEN payload bytes, CHK.
//  CHK = XOR of CMD, LEN and all payload bytes.
//  A checked frame is presented to the command decoder through a valid/ack handshake.
//  The payload is read through a random-access read port.
// PARAMETERS
//  SOF_BYTE       8'hA5        start-of-frame marker
//  MAX_PAYLOAD    16           payload buffer depth in bytes (>=1)
//  CLK_F          50_000_000   clock frequency, Hz
//  BAUD           9600         line baud rate; used for timeout sizing only
//  TIMEOUT_BYTES  4            inter-byte timeout in byte times; 1 byte time = 10*CLK_F/BAUD clks
// PORTS
//  clk            in   1    clock
//  rst            in   1    reset; asynchronous, active-high
//  i_valid        in   1    1-clk byte strobe from UART receiver
//  i_data         in   8    received byte; sampled when i_valid=1
//  i_frame_ack    in   1    consumer releases the held frame
//  i_rd_addr      in   AW   payload read index; AW=$clog2(MAX_PAYLOAD), min 1
//  o_rd_data      out  8    payload[i_rd_addr], combinational; 0 when i_rd_addr>=o_len
//  o_frame_valid  out  1    level; frame held, stable until acked
//  o_cmd          out  8    CMD of held frame
//  o_len          out  8    LEN of held frame
//  o_err          out  1    1-clk error pulse
//  o_err_code     out  3    valid with o_err: 1=checksum, 2=length, 3=timeout, 4=overrun
//  t_state        out  3    FSM state, debug
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0. Checksum, byte counter, timer and payload buffer cleared.
//  - FSM encoding: IDLE=0, CMD=1, LEN=2, PAYLOAD=3, CHK=4, HOLD=5. Unused codes -> IDLE.
//  - Each byte is consumed in the cycle i_valid=1. Any state change takes effect next clk.
//  - IDLE: byte==SOF_BYTE -> CMD; other bytes are silently discarded.
//  - CMD: store o_cmd and chk<=byte -> LEN.
//  - LEN:
//    - byte>MAX_PAYLOAD -> IDLE with o_err, code 2.
//    - byte==0 -> CHK.
//    - else -> PAYLOAD.
//    - In all cases: store o_len, chk^=byte.
//  - PAYLOAD: buf[idx]<=byte, chk^=byte, idx++. After the LEN-th byte -> CHK.
//  - CHK:
//    - byte==chk -> HOLD; o_frame_valid=1 from the next clk.
//    - mismatch -> IDLE with o_err, code 1.
//  - HOLD:
//    - o_cmd, o_len and buffer are frozen.
//    - i_frame_ack -> IDLE; o_frame_valid=0 next clk.
//    - i_valid without ack: byte dropped, o_err code 4, frame stays intact.
//    - ack and i_valid in the same clk: ack wins, and the byte is evaluated as an IDLE byte. An SOF -> CMD.
//  - Buffer and o_cmd/o_len are meaningful only while o_frame_valid=1.
//  - o_err is a single-clk pulse; o_err_code holds its value until the next error.
//  - Latency: o_frame_valid rises 1 clk after the CHK byte strobe.
//  - Reset mid-frame or mid-HOLD: immediate return to IDLE; the frame is lost, with no error pulse.
// CONFIGURATION
//  - Macro UART_FRAME_TIMEOUT_EN defined:
//    - In CMD..CHK a timer counts clocks since the last accepted byte.
//    - Reaching TIMEOUT_BYTES*10*CLK_F/BAUD -> IDLE with o_err, code 3.
//    - A byte arriving in the expiry clk wins, and the timer restarts.
//    - The timer is idle and cleared in IDLE and HOLD.
//  - Macro undefined: no timer logic; the parser waits indefinitely mid-frame.
//    - Error code 3 is never produced.
// TESTING
//  1. Good frame: A5 10 02 33 44 65 -> o_frame_valid=1, o_cmd=10, o_len=02, rd[0]=33, rd[1]=44, rd[2]=00.
//     Then ack -> o_frame_valid=0 next clk.
//  2. Bad checksum: A5 10 02 33 44 66 -> o_err pulse, code 1; state IDLE; no o_frame_valid.
//  3. Length/zero-length:
//     - A5 10 11 (MAX_PAYLOAD=16) -> o_err, code 2.
//     - Then A5 20 00 20 -> o_frame_valid=1, o_len=0.
//  4. Overrun/ack race:
//     - Hold frame from test 1, send 55 -> o_err code 4; o_cmd=10, rd[0]=33 unchanged.
//     - Send A5 together with ack -> state CMD.
//  5. Timeout (UART_FRAME_TIMEOUT_EN, CLK_F/BAUD=10, TIMEOUT_BYTES=4):
//     - A5 10 then idle 400 clks -> o_err code 3, IDLE.
//     - A byte at clk 399 -> no error.
//  6. Noise/reset: 00 FF 13 A5 10 01 7E 6F -> frame valid, o_cmd=10, rd[0]=7E.
//     - rst asserted mid-payload -> IDLE, all outputs 0.

Source files
------------

// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Assembles command frames (SOF, CMD, LEN, LEN payload bytes, CHK) from the
//   UART receiver byte stream. CHK is the XOR of CMD, LEN and every payload
//   byte. A frame that passes the check is held for the command decoder
//   (valid/ack handshake), and its payload is read through a random-access port.
//
//   Optional feature: define UART_FRAME_TIMEOUT_EN to abort a partially
//   received frame after TIMEOUT_BYTES byte times without a byte
//   (error code 3). Without the macro the parser waits indefinitely mid-frame.
//
// Ports
//   clk            clock
//   rst            asynchronous active-high reset
//   i_valid        1-clk byte strobe from the UART receiver
//   i_data         received byte, sampled when i_valid=1
//   i_frame_ack    consumer releases the held frame
//   i_rd_addr      payload read index
//   o_rd_data      payload[i_rd_addr] (combinational), 0 when i_rd_addr >= o_len
//   o_frame_valid  a checked frame is held, stable until acked
//   o_cmd          CMD of the held frame
//   o_len          LEN of the held frame
//   o_err          1-clk error pulse
//   o_err_code     1=checksum 2=length 3=timeout 4=overrun; holds until next error
//   t_state        FSM state (debug)
module uart_frame_parser #(
  parameter logic [7:0]  SOF_BYTE      = 8'hA5,
  parameter int unsigned MAX_PAYLOAD   = 16,
  parameter int unsigned CLK_F         = 50_000_000,
  parameter int unsigned BAUD          = 9600,
  parameter int unsigned TIMEOUT_BYTES = 4,
  localparam int unsigned AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic [7:0]    i_data,
  input  logic          i_frame_ack,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic          o_frame_valid,
  output logic [7:0]    o_cmd,
  output logic [7:0]    o_len,
  output logic          o_err,
  output logic [2:0]    o_err_code,
  output logic [2:0]    t_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  state_t      state_q, state_nxt;
  logic [7:0]  cmd_q, len_q, chk_q, idx_q;
  logic [7:0]  pay_buf [MAX_PAYLOAD];
  logic        err_q, err_set;
  logic [2:0]  err_code_q, err_code_set;
  logic        timeout_hit;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam longint unsigned TO_CYCLES =
    longint'(TIMEOUT_BYTES) * 10 * longint'(CLK_F) / longint'(BAUD);
  localparam int unsigned TW = $clog2(TO_CYCLES + 1);

  logic [TW-1:0] timer_q;
  logic          in_frame;

  assign in_frame = (state_q == S_CMD) || (state_q == S_LEN) ||
                    (state_q == S_PAYLOAD) || (state_q == S_CHK);
  // Timer reads k-1 on the k-th clock after the last byte, so the compare
  // fires on exactly the TO_CYCLES-th clock; a byte in that clock wins.
  assign timeout_hit = in_frame && !i_valid && (timer_q == TW'(TO_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else if (!in_frame || i_valid) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state and error decode
  always_comb begin
    state_nxt    = state_q;
    err_set      = 1'b0;
    err_code_set = '0;
    case (state_q)
      S_IDLE: begin
        if (i_valid && i_data == SOF_BYTE) state_nxt = S_CMD;
      end
      S_CMD: begin
        if (i_valid) state_nxt = S_LEN;
      end
      S_LEN: begin
        if (i_valid) begin
          if (i_data > MAX_LEN) begin
            state_nxt    = S_IDLE;
            err_set      = 1'b1;
            err_code_set = 3'd2;
          end else if (i_data == 8'd0) begin
            state_nxt = S_CHK;
          end else begin
            state_nxt = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (i_valid && (idx_q + 8'd1 == len_q)) state_nxt = S_CHK;
      end
      S_CHK: begin
        if (i_valid) begin
          if (i_data == chk_q) begin
            state_nxt = S_HOLD;
          end else begin
            state_nxt    = S_IDLE;
            err_set      = 1'b1;
            err_code_set = 3'd1;
          end
        end
      end
      S_HOLD: begin
        // Ack releases the frame; a byte in the same clock is judged as an
        // IDLE byte, so an SOF starts the next frame immediately.
        if (i_frame_ack) begin
          state_nxt = (i_valid && i_data == SOF_BYTE) ? S_CMD : S_IDLE;
        end else if (i_valid) begin
          err_set      = 1'b1;
          err_code_set = 3'd4;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (timeout_hit) begin
      state_nxt    = S_IDLE;
      err_set      = 1'b1;
      err_code_set = 3'd3;
    end
  end

  // Frame datapath: header, checksum, payload buffer, error reporting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q      <= '0;
      len_q      <= '0;
      chk_q      <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      for (int unsigned i = 0; i < MAX_PAYLOAD; i++) pay_buf[i] <= '0;
    end else begin
      err_q <= err_set;
      if (err_set) err_code_q <= err_code_set;
      if (i_valid) begin
        case (state_q)
          S_CMD: begin
            cmd_q <= i_data;
            chk_q <= i_data;
          end
          S_LEN: begin
            len_q <= i_data;
            chk_q <= chk_q ^ i_data;
            idx_q <= '0;
          end
          S_PAYLOAD: begin
            pay_buf[idx_q[AW-1:0]] <= i_data;
            chk_q <= chk_q ^ i_data;
            idx_q <= idx_q + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs
  always_comb begin
    o_frame_valid = (state_q == S_HOLD);
    t_state       = state_q;
    o_cmd         = cmd_q;
    o_len         = len_q;
    o_err         = err_q;
    o_err_code    = err_code_q;
    o_rd_data     = '0;
    if (8'(i_rd_addr) < len_q) o_rd_data = pay_buf[i_rd_addr];
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
module tb_uart_frame_parser;

  localparam int          MAXP     = 16;
  localparam int unsigned TO_LIMIT = 400;  // 4 byte times * 10 * (100/10)

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i_data = '0;
  logic       i_frame_ack = 1'b0;
  logic [3:0] i_rd_addr = '0;
  logic [7:0] o_rd_data;
  logic       o_frame_valid;
  logic [7:0] o_cmd;
  logic [7:0] o_len;
  logic       o_err;
  logic [2:0] o_err_code;
  logic [2:0] t_state;

  uart_frame_parser #(
    .SOF_BYTE     (8'hA5),
    .MAX_PAYLOAD  (16),
    .CLK_F        (100),
    .BAUD         (10),
    .TIMEOUT_BYTES(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .i_frame_ack  (i_frame_ack),
    .i_rd_addr    (i_rd_addr),
    .o_rd_data    (o_rd_data),
    .o_frame_valid(o_frame_valid),
    .o_cmd        (o_cmd),
    .o_len        (o_len),
    .o_err        (o_err),
    .o_err_code   (o_err_code),
    .t_state      (t_state)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- frame-level model ----------------
  // Bytes after SOF are collected in a queue; the frame is judged by its
  // length and contents once enough bytes have arrived.
  logic [7:0]  fr[$];
  bit          m_in   = 1'b0;
  bit          m_hold = 1'b0;
  logic [7:0]  m_cmd  = '0;
  logic [7:0]  m_len  = '0;
  logic [7:0]  m_pay [MAXP];
  bit          m_err  = 1'b0;
  logic [2:0]  m_code = '0;
  int unsigned m_since = 0;

  function automatic logic [2:0] m_state();
    int n;
    if (m_hold) return 3'd5;
    if (!m_in) return 3'd0;
    n = fr.size();
    if (n == 0) return 3'd1;
    if (n == 1) return 3'd2;
    if (n < int'(fr[1]) + 2) return 3'd3;
    return 3'd4;
  endfunction

  task automatic model_step();
    logic       v, ack;
    logic [7:0] d, x;
    bit         as_idle;
    int         n;
    v = i_valid; d = i_data; ack = i_frame_ack; as_idle = 1'b0;
    m_err = 1'b0;
    if (m_hold) begin
      if (ack) begin
        m_hold  = 1'b0;
        as_idle = v;
      end else if (v) begin
        m_err = 1'b1; m_code = 3'd4;
      end
    end else if (m_in) begin
      if (v) begin
        m_since = 0;
        fr.push_back(d);
        n = fr.size();
        if (n == 2 && int'(fr[1]) > MAXP) begin
          m_err = 1'b1; m_code = 3'd2; m_in = 1'b0;
        end else if (n >= 2 && n == int'(fr[1]) + 3) begin
          x = '0;
          for (int i = 0; i < n - 1; i++) x ^= fr[i];
          m_in = 1'b0;
          if (x == fr[n-1]) begin
            m_hold = 1'b1; m_cmd = fr[0]; m_len = fr[1];
            for (int i = 0; i < int'(fr[1]); i++) m_pay[i] = fr[i+2];
          end else begin
            m_err = 1'b1; m_code = 3'd1;
          end
        end
      end else begin
`ifdef UART_FRAME_TIMEOUT_EN
        m_since++;
        if (m_since == TO_LIMIT) begin
          m_err = 1'b1; m_code = 3'd3; m_in = 1'b0;
        end
`endif
      end
    end else begin
      as_idle = v;
    end
    if (as_idle && d == 8'hA5) begin
      m_in = 1'b1; fr.delete(); m_since = 0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_in = 1'b0; m_hold = 1'b0; m_cmd = '0; m_len = '0;
      m_err = 1'b0; m_code = '0; m_since = 0; fr.delete();
    end else begin
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [31:0] exp_rd;
    check("frame_valid", 32'(o_frame_valid), 32'(m_hold));
    check("err",         32'(o_err),         32'(m_err));
    check("err_code",    32'(o_err_code),    32'(m_code));
    check("state",       32'(t_state),       32'(m_state()));
    if (m_hold) begin
      exp_rd = (32'(i_rd_addr) < 32'(m_len)) ? 32'(m_pay[i_rd_addr]) : 32'd0;
      check("cmd",     32'(o_cmd),     32'(m_cmd));
      check("len",     32'(o_len),     32'(m_len));
      check("rd_data", 32'(o_rd_data), exp_rd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b, input bit ack = 1'b0);
    i_valid = 1'b1; i_data = b; i_frame_ack = ack;
    @(posedge clk); #1;
    i_valid = 1'b0; i_frame_ack = 1'b0;
    i_rd_addr++;
  endtask

  task automatic send_q(input logic [7:0] q[$]);
    foreach (q[i]) send(q[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      i_rd_addr++;
    end
  endtask

  task automatic ack_only();
    i_frame_ack = 1'b1;
    @(posedge clk); #1;
    i_frame_ack = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [3:0] a, input logic [7:0] exp);
    i_rd_addr = a;
    #1;
    check(name, 32'(o_rd_data), 32'(exp));
  endtask

  initial begin
    logic [7:0] bq[$];
    logic [7:0] x;

    // Reset state
    idle(3);
    check("rst_state", 32'(t_state), 32'd0);
    check("rst_valid", 32'(o_frame_valid), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_code", 32'(o_err_code), 32'd0);
    check("rst_cmd", 32'(o_cmd), 32'd0);
    rd_check("rst_rd", 4'd0, 8'h00);
    rst = 1'b0;
    idle(2);

    // Good frame, held
    bq = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h65};
    send_q(bq);
    check("t1_valid", 32'(o_frame_valid), 32'd1);
    check("t1_cmd", 32'(o_cmd), 32'h10);
    check("t1_len", 32'(o_len), 32'h02);
    rd_check("t1_rd0", 4'd0, 8'h33);
    rd_check("t1_rd1", 4'd1, 8'h44);
    rd_check("t1_rd2", 4'd2, 8'h00);
    idle(2);

    // Overrun while held, frame stays intact
    send(8'h55);
    check("t4_err", 32'(o_err), 32'd1);
    check("t4_code", 32'(o_err_code), 32'd4);
    check("t4_cmd", 32'(o_cmd), 32'h10);
    rd_check("t4_rd0", 4'd0, 8'h33);
    idle(1);

    // Ack together with SOF starts the next frame
    send(8'hA5, 1'b1);
    check("t4_state_cmd", 32'(t_state), 32'd1);
    check("t4_valid_drop", 32'(o_frame_valid), 32'd0);
    bq = '{8'h10, 8'h02, 8'h33, 8'h44, 8'h65};
    send_q(bq);
    check("t1b_valid", 32'(o_frame_valid), 32'd1);
    ack_only();
    check("t1_ack_valid", 32'(o_frame_valid), 32'd0);
    idle(2);

    // Bad checksum
    bq = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h66};
    send_q(bq);
    check("t2_err", 32'(o_err), 32'd1);
    check("t2_code", 32'(o_err_code), 32'd1);
    check("t2_state", 32'(t_state), 32'd0);
    check("t2_valid", 32'(o_frame_valid), 32'd0);
    idle(2);

    // Length too large, then zero-length frame
    bq = '{8'hA5, 8'h10, 8'h11};
    send_q(bq);
    check("t3_err", 32'(o_err), 32'd1);
    check("t3_code", 32'(o_err_code), 32'd2);
    idle(1);
    bq = '{8'hA5, 8'h20, 8'h00, 8'h20};
    send_q(bq);
    check("t3_valid", 32'(o_frame_valid), 32'd1);
    check("t3_len", 32'(o_len), 32'd0);
    rd_check("t3_rd0", 4'd0, 8'h00);
    ack_only();
    idle(1);

    // Maximum-length payload
    bq = '{8'hA5, 8'h42, 8'd16};
    x = 8'h42 ^ 8'd16;
    for (int i = 0; i < 16; i++) begin
      bq.push_back(8'(i * 17));
      x ^= 8'(i * 17);
    end
    bq.push_back(x);
    send_q(bq);
    check("max_valid", 32'(o_frame_valid), 32'd1);
    rd_check("max_rd15", 4'd15, 8'hFF);
    rd_check("max_rd1", 4'd1, 8'h11);
    ack_only();
    idle(1);

`ifdef UART_FRAME_TIMEOUT_EN
    // Byte in the expiry clock is accepted; silence through it aborts
    send(8'hA5); send(8'h10);
    idle(TO_LIMIT - 1);
    check("to_pre_state", 32'(t_state), 32'd2);
    send(8'h03);
    check("to_late_byte_state", 32'(t_state), 32'd3);
    check("to_late_byte_err", 32'(o_err), 32'd0);
    idle(TO_LIMIT - 1);
    check("to_not_yet", 32'(o_err), 32'd0);
    idle(1);
    check("to_err", 32'(o_err), 32'd1);
    check("to_code", 32'(o_err_code), 32'd3);
    check("to_state", 32'(t_state), 32'd0);
`else
    // Without the timer the parser waits mid-frame indefinitely
    send(8'hA5); send(8'h10);
    idle(TO_LIMIT + 100);
    check("nto_state", 32'(t_state), 32'd2);
    check("nto_code", 32'(o_err_code), 32'd2);
    send(8'h00); send(8'h10);
    check("nto_valid", 32'(o_frame_valid), 32'd1);
    ack_only();
`endif
    idle(2);

    // Noise before SOF
    bq = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h10, 8'h01, 8'h7E, 8'h6F};
    send_q(bq);
    check("t6_valid", 32'(o_frame_valid), 32'd1);
    check("t6_cmd", 32'(o_cmd), 32'h10);
    rd_check("t6_rd0", 4'd0, 8'h7E);
    ack_only();
    idle(1);

    // Reset mid-payload
    bq = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22};
    send_q(bq);
    rst = 1'b1;
    #1;
    check("mr_state", 32'(t_state), 32'd0);
    check("mr_valid", 32'(o_frame_valid), 32'd0);
    check("mr_cmd", 32'(o_cmd), 32'd0);
    check("mr_len", 32'(o_len), 32'd0);
    check("mr_err", 32'(o_err), 32'd0);
    check("mr_code", 32'(o_err_code), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    bq = '{8'hA5, 8'h10, 8'h01, 8'h7E, 8'h6F};
    send_q(bq);
    check("mr_recover", 32'(o_frame_valid), 32'd1);
    ack_only();
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
